smg_scan_module: RTL
====================

SMG_SCAN_MODULE -- requirements
Module: smg_scan_module

Interface
REQ-001 Parameter CLK_FREQ_HZ, default 50_000_000, input clock frequency.
REQ-002 Parameter SCAN_HZ, default 1000, per-digit refresh rate; TICK_MAX = CLK_FREQ_HZ/SCAN_HZ, minimum 2.
REQ-003 Parameter DP_POS, default 2, digit index whose decimal point is lit.
REQ-004 Parameter LZB, default 1, enables leading-zero blanking when 1.
REQ-005 CLK  input  1  clock, rising edge.
REQ-006 RSTn  input  1  reset, asynchronous, active-low.
REQ-007 Number_Sig  input  24  six BCD nibbles; nibble i = Number_Sig[4i+3:4i]; digit 0 is rightmost.
REQ-008 SMG_Data  output  8  segments {dp,g,f,e,d,c,b,a}, active-low, registered.
REQ-009 Scan_Sig  output  6  digit enables, bit i selects digit i, active-low, registered.

Function
REQ-010 The tick counter SHALL count 0..TICK_MAX-1 and wrap; at terminal count the digit index SHALL advance 0->1->...->5->0.
REQ-011 The snapshot register SHALL load Number_Sig on every cycle where counter==0 and index==0, which is frame start, including the first cycle after reset release.
REQ-012 Number_Sig changes outside frame start SHALL have no effect until the next frame start, so frames are tear-free.
REQ-013 SMG_Data and Scan_Sig SHALL be registered from the current index and snapshot, giving 1-cycle latency after any index or snapshot change.
REQ-014 Exactly one Scan_Sig bit SHALL be low at a time, except that all bits are high in reset.
REQ-015 Segment codes for a..g: 0=C0,1=F9,2=A4,3=B0,4=99,5=92,6=82,7=F8,8=80,9=90 (hex, dp bit high).
REQ-016 A nibble >9 SHALL display dash (code BF); it SHALL never be blanked.
REQ-017 With LZB=1, digits 5..3 SHALL be blanked (FF) when the digit and all higher digits are 0; digits 2..0 are never blanked.
REQ-018 SMG_Data[7] SHALL be 0 when index==DP_POS, regardless of blanking on other digits, and 1 otherwise.
REQ-019 A full frame SHALL take exactly 6*TICK_MAX cycles; no gap cycles between digits.

Reset
REQ-020 When RSTn is low: counter=0, index=0, snapshot=0, SMG_Data=FF, Scan_Sig=3F, all immediately (asynchronously).
REQ-021 Reset asserted mid-frame SHALL abort the frame; after release, scanning SHALL restart at digit 0 with a fresh snapshot.
REQ-022 On the first edge after release, outputs SHALL show digit 0 of the pre-load snapshot (0 -> C0 with dp per DP_POS); the new snapshot SHALL appear on the following edge.

Structure
REQ-023 Package smg_pkg SHALL hold NUM_DIGITS=6, segment code constants (SEG_0..SEG_9, SEG_DASH, SEG_BLANK) and the active-low polarity constants.
REQ-024 Sub-module smg_encode_module SHALL be a combinational BCD-to-segment decoder (nibble, blank, dp -> 8-bit code); the counter, index, snapshot and output registers SHALL stay in smg_scan_module.

Verification (CLK_FREQ_HZ=1000, SCAN_HZ=250 -> TICK_MAX=4)
REQ-025 Reset held, Number_Sig=012345 -> SMG_Data=FF, Scan_Sig=3F; after release, Scan_Sig steps 3E,3D,3B,37,2F,1F, every 4 cycles, then wraps to 3E.
REQ-026 Number_Sig=000150, LZB=1, DP_POS=2 -> digit0=C0, digit1=92, digit2=79 (1 with dp), digits3..5=FF.
REQ-027 Number_Sig=00A000 -> digit3=BF (dash), digits4,5=FF, digit2=40 (0 with dp).
REQ-028 Change Number_Sig from 000100 to 000900 while index==3 -> digit2 keeps showing 79 until the next frame start, then shows 10.
REQ-029 Assert RSTn low while index==4 -> outputs go FF/3F the same cycle with no clock edge; after release, the next frame starts at Scan_Sig=3E.
REQ-030 LZB=0, Number_Sig=000000 -> all six digits show C0; digit2 shows 40.

Source files
------------

// File: rtl/smg_pkg.sv
// Shared constants for the six-digit seven-segment scanner.
// Segment codes are {dp,g,f,e,d,c,b,a}, active-low, with dp off.
package smg_pkg;

  localparam int NUM_DIGITS      = 6;
  localparam int DIGIT_W         = 4;
  localparam int IDX_W           = 3;
  localparam int BLANK_MIN_DIGIT = 3;

  typedef logic [IDX_W-1:0] digit_idx_t;

  localparam logic SEG_ON  = 1'b0;
  localparam logic SEG_OFF = 1'b1;
  localparam logic DIG_ON  = 1'b0;
  localparam logic DIG_OFF = 1'b1;

  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_DASH  = 8'hBF;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Active-low one-hot digit enable for the given index.
  function automatic logic [NUM_DIGITS-1:0] digit_sel(input digit_idx_t idx);
    logic [NUM_DIGITS-1:0] sel;
    sel = {NUM_DIGITS{DIG_OFF}};
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (int'(idx) == i) begin
        sel[i] = DIG_ON;
      end else begin
        sel[i] = DIG_OFF;
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/smg_scan_if.sv
// Display bus: BCD value in, active-low segment and digit drives out.
interface smg_scan_if;
  import smg_pkg::*;

  logic [DIGIT_W*NUM_DIGITS-1:0] Number_Sig;
  logic [7:0]                    SMG_Data;
  logic [NUM_DIGITS-1:0]         Scan_Sig;

  modport master (output Number_Sig, input SMG_Data, input Scan_Sig);
  modport slave  (input Number_Sig, output SMG_Data, output Scan_Sig);
endinterface

// File: rtl/smg_encode_module.sv
// Combinational BCD-to-segment decoder; non-decimal nibbles show a dash.
module smg_encode_module
  import smg_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       blank,
  input  logic       dp,
  output logic [7:0] code
);

  // Digit glyph first, then the decimal point overrides bit 7.
  always_comb begin
    code = SEG_BLANK;
    if (blank) begin
      code = SEG_BLANK;
    end else begin
      case (nibble)
        4'd0:    code = SEG_0;
        4'd1:    code = SEG_1;
        4'd2:    code = SEG_2;
        4'd3:    code = SEG_3;
        4'd4:    code = SEG_4;
        4'd5:    code = SEG_5;
        4'd6:    code = SEG_6;
        4'd7:    code = SEG_7;
        4'd8:    code = SEG_8;
        4'd9:    code = SEG_9;
        default: code = SEG_DASH;
      endcase
    end
    code[7] = dp ? SEG_ON : SEG_OFF;
  end

endmodule

// File: rtl/smg_scan_module.sv
// Multiplexed six-digit display scanner with per-frame snapshot of the value,
// optional leading-zero blanking and a fixed decimal point.
module smg_scan_module
  import smg_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int SCAN_HZ     = 1000,
  parameter int DP_POS      = 2,
  parameter int LZB         = 1
) (
  input  logic       CLK,
  input  logic       RSTn,
  smg_scan_if.slave  bus
);

  localparam int TICK_RAW = CLK_FREQ_HZ / SCAN_HZ;
  localparam int TICK_MAX = (TICK_RAW < 2) ? 2 : TICK_RAW;
  localparam int CW       = $clog2(TICK_MAX);
  localparam int SNAP_W   = DIGIT_W * NUM_DIGITS;

  logic [CW-1:0]         cnt_q, cnt_d;
  digit_idx_t            idx_q, idx_d;
  logic [SNAP_W-1:0]     snap_q, snap_d;
  logic [7:0]            seg_q, seg_d;
  logic [NUM_DIGITS-1:0] scan_q, scan_d;

  logic       frame_start;
  logic [3:0] cur_nib;
  logic       cur_blank;
  logic       higher_zero;
  logic       dp_on;
  logic [7:0] enc_code;

  // Tick counter, digit index and frame-start snapshot.
  always_comb begin
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    snap_d      = snap_q;
    frame_start = (cnt_q == CW'(0)) && (idx_q == 3'd0);
    if (frame_start) begin
      snap_d = bus.Number_Sig;
    end else begin
      snap_d = snap_q;
    end
    if (cnt_q == CW'(TICK_MAX - 1)) begin
      cnt_d = CW'(0);
      if (idx_q == 3'(NUM_DIGITS - 1)) begin
        idx_d = 3'd0;
      end else begin
        idx_d = idx_q + 3'd1;
      end
    end else begin
      cnt_d = cnt_q + CW'(1);
      idx_d = idx_q;
    end
  end

  // Walk from the top digit down so a digit is blanked only when it and
  // everything above it is zero.
  always_comb begin
    cur_nib     = 4'd0;
    cur_blank   = 1'b0;
    higher_zero = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      higher_zero = higher_zero && (snap_q[DIGIT_W*i +: DIGIT_W] == 4'd0);
      if (int'(idx_q) == i) begin
        cur_nib   = snap_q[DIGIT_W*i +: DIGIT_W];
        cur_blank = (LZB == 1) && (i >= BLANK_MIN_DIGIT) && higher_zero;
      end else begin
        cur_blank = cur_blank;
      end
    end
    dp_on = (int'(idx_q) == DP_POS);
  end

  smg_encode_module u_encode (
    .nibble (cur_nib),
    .blank  (cur_blank),
    .dp     (dp_on),
    .code   (enc_code)
  );

  // Output drive follows the index/snapshot with one cycle of latency.
  always_comb begin
    seg_d  = enc_code;
    scan_d = digit_sel(idx_q);
  end

  // State and output registers.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      cnt_q  <= CW'(0);
      idx_q  <= 3'd0;
      snap_q <= {SNAP_W{1'b0}};
      seg_q  <= SEG_BLANK;
      scan_q <= {NUM_DIGITS{DIG_OFF}};
    end else begin
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      snap_q <= snap_d;
      seg_q  <= seg_d;
      scan_q <= scan_d;
    end
  end

  assign bus.SMG_Data = seg_q;
  assign bus.Scan_Sig = scan_q;

endmodule
